// File: rtl/exm_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exm_stack_sequencer
// Brief    : Handshaked stack engine for the execute-memory stage. Runs
//            PUSH / POP / CALL / RET against a synchronous-read data memory,
//            keeps the stack pointer, rejects overflowing/underflowing
//            operations and returns popped data, PC and flags.
// Revision : 1.0 - initial release
// ============================================================================
module exm_stack_sequencer #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                PC_WORDS    = 2,
    parameter logic [ADDR_W-1:0] SP_RESET    = {ADDR_W{1'b1}},
    parameter logic [ADDR_W-1:0] STACK_LIMIT = '0,
    parameter bit                SAVE_FLAGS  = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [1:0]                 i_op,
    input  logic [DATA_W-1:0]          i_data,
    input  logic [DATA_W*PC_WORDS-1:0] i_pc,
    input  logic [2:0]                 i_flags,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [DATA_W-1:0]          o_mem_wdata,
    output logic                       o_mem_we,
    output logic                       o_mem_re,
    input  logic [DATA_W-1:0]          i_mem_rdata,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [DATA_W*PC_WORDS-1:0] o_pc,
    output logic [2:0]                 o_flags,
    output logic                       o_flags_load,
    output logic                       o_done,
    output logic                       o_overflow,
    output logic                       o_underflow,
    output logic [ADDR_W-1:0]          o_sp
);

    localparam int                c_PC_W     = DATA_W * PC_WORDS;
    localparam int                c_CNT_W    = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PC_WORDS - 1);
    localparam logic [ADDR_W:0]   c_N_PC     = (ADDR_W + 1)'(PC_WORDS);
    localparam logic [ADDR_W:0]   c_N_ONE    = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_sp;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  r_last;
    logic                r_multi;
    logic [c_PC_W-1:0]   r_wbuf;
    logic [c_PC_W-1:0]   r_rbuf;

    logic [ADDR_W:0]     w_n;
    logic [ADDR_W:0]     w_sp_ext;
    logic [ADDR_W:0]     w_room;
    logic                w_ovf;
    logic                w_unf;
    logic [c_CNT_W-1:0]  w_cnt_m1;
    logic [c_PC_W-1:0]   w_call_word;
    logic [c_PC_W-1:0]   w_ret_pc;
    logic [2:0]          w_ret_flags;

    // Limit checks in ADDR_W+1 bits; op[0]=0 is push-type, op[1]=1 is multi-word.
    assign w_n      = i_op[1] ? c_N_PC : c_N_ONE;
    assign w_sp_ext = {1'b0, r_sp};
    assign w_room   = w_sp_ext - {1'b0, STACK_LIMIT} + c_N_ONE;
    assign w_ovf    = ~i_op[0] & (w_room < w_n);
    assign w_unf    = i_op[0] & ((w_sp_ext + w_n) > {1'b0, SP_RESET});
    assign w_cnt_m1 = r_cnt - c_CNT_W'(1);

    assign o_req_ready = (r_state == S_IDLE);
    assign o_sp        = r_sp;

    // CALL image: flags replace the top three PC bits when saving is enabled.
    always_comb begin
        w_call_word = i_pc;
        if (SAVE_FLAGS) begin
            w_call_word[c_PC_W-1 -: 3] = i_flags;
        end
    end

    // RET image: the last word arrives straight from memory; split flags off the top.
    always_comb begin
        w_ret_pc                      = r_rbuf;
        w_ret_pc[c_PC_W-1 -: DATA_W]  = i_mem_rdata;
        w_ret_flags                   = 3'b000;
        if (SAVE_FLAGS) begin
            w_ret_flags                = w_ret_pc[c_PC_W-1 -: 3];
            w_ret_pc[c_PC_W-1 -: 3]    = 3'b000;
        end
    end

    // Sequencer: request acceptance, memory strobes, SP update and result registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_sp         <= SP_RESET;
            r_cnt        <= '0;
            r_last       <= '0;
            r_multi      <= 1'b0;
            r_wbuf       <= '0;
            r_rbuf       <= '0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_we     <= 1'b0;
            o_mem_re     <= 1'b0;
            o_rdata      <= '0;
            o_pc         <= '0;
            o_flags      <= 3'b000;
            o_flags_load <= 1'b0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_underflow  <= 1'b0;
        end else begin
            o_mem_we     <= 1'b0;
            o_mem_re     <= 1'b0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_underflow  <= 1'b0;
            o_flags_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_multi <= i_op[1];
                        if (w_ovf) begin
                            o_overflow <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (w_unf) begin
                            o_underflow <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (!i_op[0]) begin
                            // Highest PC word goes first so word 0 ends up on top.
                            o_mem_we    <= 1'b1;
                            o_mem_addr  <= r_sp;
                            o_mem_wdata <= i_op[1] ? w_call_word[c_PC_W-1 -: DATA_W] : i_data;
                            r_wbuf      <= w_call_word;
                            r_cnt       <= i_op[1] ? c_CNT_LAST : '0;
                            r_sp        <= r_sp - ADDR_W'(1);
                            o_done      <= ~i_op[1] | (PC_WORDS == 1);
                            r_state     <= S_WRITE;
                        end else begin
                            o_mem_re    <= 1'b1;
                            o_mem_addr  <= r_sp + ADDR_W'(1);
                            r_sp        <= r_sp + ADDR_W'(1);
                            r_cnt       <= '0;
                            r_last      <= i_op[1] ? c_CNT_LAST : '0;
                            r_state     <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_cnt != '0) begin
                        o_mem_we    <= 1'b1;
                        o_mem_addr  <= r_sp;
                        o_mem_wdata <= r_wbuf[w_cnt_m1*DATA_W +: DATA_W];
                        r_sp        <= r_sp - ADDR_W'(1);
                        r_cnt       <= w_cnt_m1;
                        o_done      <= (w_cnt_m1 == '0);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    // Data for the read issued last cycle is on i_mem_rdata now.
                    if (r_cnt != '0) begin
                        r_rbuf[w_cnt_m1*DATA_W +: DATA_W] <= i_mem_rdata;
                    end
                    if (r_cnt != r_last) begin
                        o_mem_re   <= 1'b1;
                        o_mem_addr <= r_sp + ADDR_W'(1);
                        r_sp       <= r_sp + ADDR_W'(1);
                        r_cnt      <= r_cnt + c_CNT_W'(1);
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    o_done  <= 1'b1;
                    r_state <= S_DONE;
                    if (r_multi) begin
                        o_pc <= w_ret_pc;
                        if (SAVE_FLAGS) begin
                            o_flags      <= w_ret_flags;
                            o_flags_load <= 1'b1;
                        end
                    end else begin
                        o_rdata <= i_mem_rdata;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exm_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exm_stack_sequencer
// Brief    : Scoreboard bench for exm_stack_sequencer. Per-cycle expected
//            strobes and results are queued when a request is driven and
//            popped as the DUT advances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exm_stack_sequencer;

    localparam logic [1:0] c_PUSH = 2'b00, c_POP = 2'b01, c_CALL = 2'b10, c_RET = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] data = '0;
    logic [31:0] pc = '0;
    logic [2:0]  flags = '0;

    logic        rdy_a, we_a, re_a, fload_a, done_a, ovf_a, unf_a;
    logic [15:0] addr_a, wdata_a, mrd_a, rdata_a, sp_a;
    logic [31:0] pc_a;
    logic [2:0]  flags_a;
    logic        rdy_b, we_b, re_b, fload_b, done_b, ovf_b, unf_b;
    logic [15:0] addr_b, wdata_b, mrd_b, rdata_b, sp_b;
    logic [31:0] pc_b;
    logic [2:0]  flags_b;

    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];

    exm_stack_sequencer dut_a (
        .i_clk(clk), .i_reset(rst_n), .i_req_valid(valid_a), .o_req_ready(rdy_a),
        .i_op(op), .i_data(data), .i_pc(pc), .i_flags(flags),
        .o_mem_addr(addr_a), .o_mem_wdata(wdata_a), .o_mem_we(we_a), .o_mem_re(re_a),
        .i_mem_rdata(mrd_a), .o_rdata(rdata_a), .o_pc(pc_a), .o_flags(flags_a),
        .o_flags_load(fload_a), .o_done(done_a), .o_overflow(ovf_a),
        .o_underflow(unf_a), .o_sp(sp_a)
    );

    exm_stack_sequencer #(.STACK_LIMIT(16'hFFFE)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_req_valid(valid_b), .o_req_ready(rdy_b),
        .i_op(op), .i_data(data), .i_pc(pc), .i_flags(flags),
        .o_mem_addr(addr_b), .o_mem_wdata(wdata_b), .o_mem_we(we_b), .o_mem_re(re_b),
        .i_mem_rdata(mrd_b), .o_rdata(rdata_b), .o_pc(pc_b), .o_flags(flags_b),
        .o_flags_load(fload_b), .o_done(done_b), .o_overflow(ovf_b),
        .o_underflow(unf_b), .o_sp(sp_b)
    );

    // Synchronous-read data memories, one per DUT.
    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= wdata_a;
        if (re_a) mrd_a <= mem_a[addr_a];
        if (we_b) mem_b[addr_b] <= wdata_b;
        if (re_b) mrd_b <= mem_b[addr_b];
    end

    typedef struct packed {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        done;
        logic        ovf;
        logic        unf;
        logic        fload;
        logic        rdy;
        logic [15:0] sp;
    } cyc_t;

    typedef struct packed {
        logic        is_ret;
        logic [15:0] rdata;
        logic [31:0] pc;
        logic [2:0]  flags;
    } res_t;

    cyc_t exp_q[$];
    res_t res_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic cyc_t observe(bit sel);
        cyc_t c;
        if (!sel) c = '{we_a, re_a, addr_a, wdata_a, done_a, ovf_a, unf_a, fload_a, rdy_a, sp_a};
        else      c = '{we_b, re_b, addr_b, wdata_b, done_b, ovf_b, unf_b, fload_b, rdy_b, sp_b};
        return c;
    endfunction

    // Address/data only matter while a strobe is expected.
    function automatic cyc_t dont_care(cyc_t c, cyc_t m);
        cyc_t r = c;
        if (!(m.we || m.re)) r.addr = '0;
        if (!m.we) r.wdata = '0;
        return r;
    endfunction

    function automatic cyc_t idle(logic [15:0] sp);
        return '{1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sp};
    endfunction

    function automatic cyc_t wr(logic [15:0] a, logic [15:0] d, logic dn, logic [15:0] sp);
        return '{1'b1, 1'b0, a, d, dn, 1'b0, 1'b0, 1'b0, 1'b0, sp};
    endfunction

    function automatic cyc_t rd(logic [15:0] a, logic [15:0] sp);
        return '{1'b0, 1'b1, a, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sp};
    endfunction

    function automatic cyc_t busy(logic [15:0] sp, logic dn, logic ov, logic un, logic fl);
        return '{1'b0, 1'b0, 16'h0, 16'h0, dn, ov, un, fl, 1'b0, sp};
    endfunction

    task automatic drive(logic [1:0] o, logic [15:0] d, logic [31:0] p, logic [2:0] f, bit sel);
        @(negedge clk);
        op = o; data = d; pc = p; flags = f;
        if (!sel) valid_a = 1'b1; else valid_b = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({observe(0), addr_a, wdata_a, rdata_a, pc_a, flags_a} !== {idle(16'hFFFF), 16'h0, 16'h0, 16'h0, 32'h0, 3'h0}) begin
            n_bad++;
            $display("FAIL reset_a: got %h/%h/%h/%h/%h/%h want %h and zeros", observe(0), addr_a, wdata_a, rdata_a, pc_a, flags_a, idle(16'hFFFF));
        end
        n_vec++;
        if ({observe(1), addr_b, wdata_b, rdata_b, pc_b, flags_b} !== {idle(16'hFFFF), 16'h0, 16'h0, 16'h0, 32'h0, 3'h0}) begin
            n_bad++;
            $display("FAIL reset_b: got %h/%h/%h/%h/%h/%h want %h and zeros", observe(1), addr_b, wdata_b, rdata_b, pc_b, flags_b, idle(16'hFFFF));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_push_pop();
        cyc_t e, o;
        res_t r;
        drive(c_PUSH, 16'hABCD, 32'h0, 3'h0, 0);
        exp_q.push_back(wr(16'hFFFF, 16'hABCD, 1'b1, 16'hFFFE));
        exp_q.push_back(idle(16'hFFFE));
        while (exp_q.size() != 0) begin
            @(negedge clk); valid_a = 1'b0;
            e = exp_q.pop_front(); o = dont_care(observe(0), e);
            n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL push: got %h want %h", o, e); end
        end
        drive(c_POP, 16'h0, 32'h0, 3'h0, 0);
        exp_q.push_back(rd(16'hFFFF, 16'hFFFF));
        exp_q.push_back(busy(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(busy(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(idle(16'hFFFF));
        res_q.push_back('{1'b0, 16'hABCD, 32'h0, 3'h0});
        while (exp_q.size() != 0) begin
            @(negedge clk); valid_a = 1'b0;
            e = exp_q.pop_front(); o = dont_care(observe(0), e);
            n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL pop: got %h want %h", o, e); end
            if (o.done && res_q.size() != 0) begin
                r = res_q.pop_front();
                n_vec++;
                if (rdata_a !== r.rdata) begin n_bad++; $display("FAIL pop_rdata: got %h want %h", rdata_a, r.rdata); end
            end
        end
    endtask

    task automatic test_call_ret();
        cyc_t e, o;
        res_t r;
        drive(c_CALL, 16'h0, 32'h0001_2345, 3'b101, 0);
        exp_q.push_back(wr(16'hFFFF, 16'hA001, 1'b0, 16'hFFFE));
        exp_q.push_back(wr(16'hFFFE, 16'h2345, 1'b1, 16'hFFFD));
        exp_q.push_back(idle(16'hFFFD));
        while (exp_q.size() != 0) begin
            @(negedge clk); valid_a = 1'b0;
            e = exp_q.pop_front(); o = dont_care(observe(0), e);
            n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL call: got %h want %h", o, e); end
        end
        drive(c_RET, 16'h0, 32'h0, 3'h0, 0);
        exp_q.push_back(rd(16'hFFFE, 16'hFFFE));
        exp_q.push_back(rd(16'hFFFF, 16'hFFFF));
        exp_q.push_back(busy(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(busy(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(idle(16'hFFFF));
        res_q.push_back('{1'b1, 16'h0, 32'h0001_2345, 3'b101});
        while (exp_q.size() != 0) begin
            @(negedge clk); valid_a = 1'b0;
            e = exp_q.pop_front(); o = dont_care(observe(0), e);
            n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL ret: got %h want %h", o, e); end
            if (o.done && res_q.size() != 0) begin
                r = res_q.pop_front();
                n_vec++;
                if ({pc_a, flags_a, rdata_a} !== {r.pc, r.flags, 16'hABCD}) begin
                    n_bad++;
                    $display("FAIL ret_result: got pc %h flags %b rdata %h want pc %h flags %b rdata abcd", pc_a, flags_a, rdata_a, r.pc, r.flags);
                end
            end
        end
    endtask

    task automatic test_underflow();
        cyc_t e, o;
        drive(c_POP, 16'h0, 32'h0, 3'h0, 0);
        exp_q.push_back(busy(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(idle(16'hFFFF));
        while (exp_q.size() != 0) begin
            @(negedge clk); valid_a = 1'b0;
            e = exp_q.pop_front(); o = dont_care(observe(0), e);
            n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL underflow: got %h want %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t e, o;
        res_t r;
        drive(c_PUSH, 16'h1111, 32'h0, 3'h0, 0);
        exp_q.push_back(wr(16'hFFFF, 16'h1111, 1'b1, 16'hFFFE));
        exp_q.push_back(idle(16'hFFFE));
        exp_q.push_back(wr(16'hFFFE, 16'h2222, 1'b1, 16'hFFFD));
        exp_q.push_back(idle(16'hFFFD));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) data = 16'h2222;
            if (i == 2) valid_a = 1'b0;
            e = exp_q.pop_front(); o = dont_care(observe(0), e);
            n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL b2b_push[%0d]: got %h want %h", i, o, e); end
        end
        drive(c_POP, 16'h0, 32'h0, 3'h0, 0);
        exp_q.push_back(rd(16'hFFFE, 16'hFFFE));
        exp_q.push_back(busy(16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(busy(16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(idle(16'hFFFE));
        exp_q.push_back(rd(16'hFFFF, 16'hFFFF));
        exp_q.push_back(busy(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(busy(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(idle(16'hFFFF));
        res_q.push_back('{1'b0, 16'h2222, 32'h0, 3'h0});
        res_q.push_back('{1'b0, 16'h1111, 32'h0, 3'h0});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 4) valid_a = 1'b0;
            e = exp_q.pop_front(); o = dont_care(observe(0), e);
            n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL b2b_pop[%0d]: got %h want %h", i, o, e); end
            if (o.done && res_q.size() != 0) begin
                r = res_q.pop_front();
                n_vec++;
                if (rdata_a !== r.rdata) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rdata_a, r.rdata); end
            end
        end
        n_vec++;
        if (res_q.size() != 0) begin n_bad++; $display("FAIL b2b_results: got %0d left want 0", res_q.size()); res_q.delete(); end
    endtask

    task automatic test_limit();
        cyc_t e, o;
        drive(c_CALL, 16'h0, 32'h0001_2345, 3'b101, 1);
        exp_q.push_back(wr(16'hFFFF, 16'hA001, 1'b0, 16'hFFFE));
        exp_q.push_back(wr(16'hFFFE, 16'h2345, 1'b1, 16'hFFFD));
        exp_q.push_back(idle(16'hFFFD));
        while (exp_q.size() != 0) begin
            @(negedge clk); valid_b = 1'b0;
            e = exp_q.pop_front(); o = dont_care(observe(1), e);
            n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL limit_call: got %h want %h", o, e); end
        end
        drive(c_PUSH, 16'h5A5A, 32'h0, 3'h0, 1);
        exp_q.push_back(busy(16'hFFFD, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(idle(16'hFFFD));
        while (exp_q.size() != 0) begin
            @(negedge clk); valid_b = 1'b0;
            e = exp_q.pop_front(); o = dont_care(observe(1), e);
            n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL limit_push: got %h want %h", o, e); end
        end
    endtask

    task automatic test_reset_mid_call();
        cyc_t o;
        drive(c_CALL, 16'h0, 32'h0003_0042, 3'b010, 0);
        @(negedge clk); valid_a = 1'b0;
        o = observe(0);
        n_vec++;
        if (o !== wr(16'hFFFF, 16'h4003, 1'b0, 16'hFFFE)) begin
            n_bad++; $display("FAIL midcall_write: got %h want %h", o, wr(16'hFFFF, 16'h4003, 1'b0, 16'hFFFE));
        end
        rst_n = 1'b0;
        #1;
        o = observe(0);
        n_vec++;
        if ({o, rdata_a, pc_a} !== {idle(16'hFFFF), 16'h0, 32'h0}) begin
            n_bad++; $display("FAIL midcall_reset: got %h/%h/%h want %h and zeros", o, rdata_a, pc_a, idle(16'hFFFF));
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            o = observe(0);
            n_vec++;
            if (o !== idle(16'hFFFF)) begin n_bad++; $display("FAIL midcall_after[%0d]: got %h want %h", i, o, idle(16'hFFFF)); end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_call_ret();
        test_underflow();
        test_back_to_back();
        test_limit();
        test_reset_mid_call();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exm_stack_sequencer.md
Name: exm_stack_sequencer

Overview:
Parametrised stack engine for the execute-memory stage. It replaces single-word push/pop with a handshaked FSM that runs PUSH, POP, CALL (a multi-word PC push with optional flag save) and RET (a multi-word PC pop with flag restore) against a synchronous-read data memory. It maintains the stack pointer, detects overflow and underflow, and returns popped data, PC and flags to the pipeline.

Parameters:
DATA_W, 16, memory word width
ADDR_W, 16, memory address width
PC_WORDS, 2, memory words per PC (PC width = DATA_W*PC_WORDS)
SP_RESET, 2**ADDR_W-1, stack pointer value after reset (empty stack)
STACK_LIMIT, 0, lowest address the stack may write
SAVE_FLAGS, 1, 1: CALL embeds {C,N,Z} in the top 3 PC bits and RET restores them

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_req_valid  in  1  operation request
o_req_ready  out  1  high only in IDLE
i_op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
i_data  in  DATA_W  PUSH data
i_pc  in  DATA_W*PC_WORDS  CALL return address
i_flags  in  3  {C,N,Z} to save on CALL
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
o_mem_we  out  1  memory write strobe
o_mem_re  out  1  memory read strobe
i_mem_rdata  in  DATA_W  read data, valid the cycle after o_mem_re
o_rdata  out  DATA_W  POP result
o_pc  out  DATA_W*PC_WORDS  RET result
o_flags  out  3  restored {C,N,Z}
o_flags_load  out  1  1-cycle pulse on RET completion when SAVE_FLAGS=1
o_done  out  1  1-cycle completion pulse
o_overflow  out  1  1-cycle pulse: push-type operation rejected
o_underflow  out  1  1-cycle pulse: pop-type operation rejected
o_sp  out  ADDR_W  current stack pointer

Behaviour:
- Reset (async, i_reset=0):
  - State goes to IDLE and SP to SP_RESET.
  - All outputs are 0 except o_req_ready=1 and o_sp=SP_RESET.
  - A reset in the middle of an operation aborts it immediately. Words already written stay in memory; no o_done is issued.
- SP convention: SP addresses the next free word. A push writes at SP, then decrements. A pop increments, then reads.
- Handshake:
  - A request is accepted in cycle T when i_req_valid and o_req_ready are both high.
  - i_op, i_data, i_pc and i_flags are captured at T.
  - o_req_ready is low from T+1 until the FSM returns to IDLE.
  - Requests made while ready is low are ignored; the requester holds them.
- n = 1 for PUSH/POP and PC_WORDS for CALL/RET.
- All error checks are made at T in ADDR_W+1-bit arithmetic:
  - Overflow when SP-STACK_LIMIT+1 < n.
  - Underflow when SP+n > SP_RESET.
  - A rejected operation pulses o_overflow or o_underflow at T+1, makes no memory access, leaves SP unchanged, gives no o_done, and returns to IDLE (ready at T+2).
- All memory and result outputs are registered.
- PUSH:
  - At T+1: we=1, addr=SP, wdata=i_data; SP <= SP-1; o_done=1.
  - IDLE again at T+2.
- CALL:
  - Writes words k = PC_WORDS-1 down to 0, one per cycle, in cycles T+1 .. T+PC_WORDS.
  - Addresses are SP, SP-1, ...; SP decrements each write.
  - When SAVE_FLAGS=1, the top 3 bits of word PC_WORDS-1 are replaced by {C,N,Z}.
  - o_done is asserted with the last write.
- POP:
  - At T+1: re=1, addr=SP+1; SP <= SP+1.
  - Data is captured at T+2.
  - At T+3: o_done=1 and o_rdata is valid.
- RET:
  - Reads word 0, 1, ... at SP+1, SP+2, ... in cycles T+1 .. T+PC_WORDS; SP increments each read.
  - Data is captured one cycle after each read.
  - At T+PC_WORDS+2: o_done=1.
  - With SAVE_FLAGS=1: o_flags_load=1, o_flags = top 3 bits of word PC_WORDS-1, and o_pc has those 3 bits cleared.
- Hold rules:
  - o_rdata, o_pc and o_flags hold their value until the next completion of the same type.
  - o_mem_we and o_mem_re are 0 in every cycle the FSM is not accessing memory.
- FSM states: IDLE, WRITE (word counter), READ (word counter), CAPTURE, DONE.
- Wrap-around of SP is impossible by construction, because the limit checks run first.

Test Plan:
1. Reset -> o_sp=FFFF, o_req_ready=1, every other output 0.
2. PUSH 0xABCD, then POP:
   - Push at T+1: we, addr FFFF, data ABCD, o_done, o_sp FFFE.
   - Pop: re at addr FFFF at T+1; o_done and o_rdata=ABCD at T+3; o_sp FFFF.
3. CALL pc=0x0001_2345, flags=101, then RET:
   - CALL writes FFFF<=A001, then FFFE<=2345; o_sp FFFD.
   - RET reads FFFE, then FFFF.
   - At T+4: o_pc=0x0001_2345, o_flags=101, o_flags_load=1, o_done=1.
4. POP right after reset -> o_underflow at T+1, no o_mem_re, o_sp stays FFFF, ready at T+2.
5. STACK_LIMIT=FFFE:
   - CALL succeeds; o_sp FFFD.
   - A following PUSH gives o_overflow, no write, o_sp FFFD.
6. Reset asserted during CALL after the first write -> o_mem_we drops immediately, o_sp=FFFF, no o_done, o_req_ready=1.
